serial_digit_adder: RTL and testbench

Multi-cycle, parametrised two's-complement adder/subtractor. Processes DIGIT bits per clock through a ripple full-adder slice, least-significant digit first, so WIDTH-bit operands need WIDTH/DIGIT cycles. Generalises the single-bit full adder to arbitrary width, adds subtract mode and signed-overflow detection, and uses valid/ready handshakes on both input and output. Sits between operand registers and the lab datapath result bus.

---
 rtl/serial_digit_adder.sv | 220 ++++++++++++++++++++++
 tb/tb_serial_digit_adder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_digit_adder.sv
// -----------------------------------------------------------------------------
// serial_digit_adder
//
// Multi-cycle two's-complement adder/subtractor. Operands are captured on the
// accepting edge and then pushed through a DIGIT-bit ripple adder, least
// significant digit first, one digit per clock. A WIDTH-bit operation therefore
// takes N = WIDTH/DIGIT RUN cycles before the result is offered downstream.
//
// Parameters
//   WIDTH     operand/result width in bits (>= 2)
//   DIGIT     bits processed per clock; must divide WIDTH exactly
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands present
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       operands
//   carry_in   carry (add) or borrow (sub) input
//   sub        0: a + b + carry_in, 1: a - b - carry_in
//   out_valid  result available (high only in DONE)
//   out_ready  consumer takes the result
//   result     sum or difference, modulo 2^WIDTH
//   carry_out  raw carry out of the MSB (for sub, 1 means no borrow)
//   overflow   signed overflow (carry into MSB xor carry out of MSB)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Input and output transfers never coincide, since in_ready is only
// high in IDLE and out_valid only in DONE. Outputs are held stable in DONE for
// as long as out_ready stays low.
//
// Optional build macro
//   SERIAL_DIGIT_ADDER_SAT_EN  when defined, an overflowing result is replaced
//                              by the signed saturation value on the final RUN
//                              edge; carry_out/overflow still report raw values.
// -----------------------------------------------------------------------------
module serial_digit_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_digit_adder: WIDTH must be >= 2 and divisible by DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Datapath state. b_q holds the already-inverted B for subtraction, and
  // carry_q starts as carry_in ^ sub, so subtract is just A + ~B + ~borrow.
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_out_q, overflow_q;

  logic             accept;
  logic             last_digit;

  logic [DIGIT-1:0] a_dig, b_dig, sum_dig;
  logic [DIGIT:0]   c;
  logic [WIDTH-1:0] result_d, result_fin;
  logic             ovf_d;

  assign last_digit = (cnt_q == CW'(N - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_digit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Digit select and ripple slice
  // ---------------------------------------------------------------------------
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int d = 0; d < N; d++) begin
      if (cnt_q == CW'(d)) begin
        a_dig = a_q[d*DIGIT +: DIGIT];
        b_dig = b_q[d*DIGIT +: DIGIT];
      end
    end
  end

  always_comb begin
    c       = '0;
    sum_dig = '0;
    c[0]    = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      sum_dig[i] = a_dig[i] ^ b_dig[i] ^ c[i];
      c[i+1]     = (a_dig[i] & b_dig[i]) | (c[i] & (a_dig[i] ^ b_dig[i]));
    end
  end

  // On the last digit, c[DIGIT-1] is the carry into the word's MSB.
  assign ovf_d = c[DIGIT-1] ^ c[DIGIT];

  always_comb begin
    result_d = result_q;
    for (int d = 0; d < N; d++) begin
      if (cnt_q == CW'(d)) begin
        result_d[d*DIGIT +: DIGIT] = sum_dig;
      end
    end
  end

`ifdef SERIAL_DIGIT_ADDER_SAT_EN
  // Signed overflow only happens when both effective operands share a sign,
  // so A's MSB tells which direction the true result ran off to.
  always_comb begin
    result_fin = result_d;
    if (ovf_d) begin
      if (a_q[WIDTH-1]) begin
        result_fin = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        result_fin = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end
`else
  assign result_fin = result_d;
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b ^ {WIDTH{sub}};
      carry_q <= carry_in ^ sub;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      carry_q <= c[DIGIT];
      if (last_digit) begin
        result_q    <= result_fin;
        carry_out_q <= c[DIGIT];
        overflow_q  <= ovf_d;
        cnt_q       <= '0;
      end else begin
        result_q <= result_d;
        cnt_q    <= cnt_q + CW'(1);
      end
    end
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_digit_adder
//
// Directed bench for serial_digit_adder at WIDTH=8, DIGIT=2 (four digits).
// The driver issues operations and pushes hand-computed expected responses
// and accept times into queues; a negedge monitor pops and compares whenever
// the DUT presents a result, and also checks latency, hold stability under
// backpressure and the return to IDLE after each output transfer.
// -----------------------------------------------------------------------------
module tb_serial_digit_adder;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;

`ifdef SERIAL_DIGIT_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_digit_adder #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W+1:0] exp_q[$];   // {result, carry_out, overflow}
  int           lat_q[$];   // cycle count just after each accepting edge
  int           errors = 0;
  int           checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic         prev_valid = 1'b0;
  logic         prev_xfer = 1'b0;
  logic [W+1:0] held = '0;
  logic [W+1:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
    end else begin
      if (prev_xfer) begin
        check("post_xfer_out_valid", out_valid, 0);
        check("post_xfer_in_ready", in_ready, 1);
      end
      if (out_valid) begin
        check("done_in_ready", in_ready, 0);
        if (!prev_valid) begin
          if (lat_q.size() == 0) fail_now("unexpected_out_valid");
          else check("latency", cyc - lat_q.pop_front(), N);
        end else begin
          check("hold_stable", {result, carry_out, overflow}, held);
        end
        held = {result, carry_out, overflow};
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            e = exp_q.pop_front();
            check("result", result, e[W+1:2]);
            check("carry_out", carry_out, e[1]);
            check("overflow", overflow, e[0]);
          end
        end
      end
      prev_valid = out_valid;
      prev_xfer  = out_valid && out_ready;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all steps land #1 after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready(output bit ok);
    int t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    ok = in_ready;
    if (!ok) fail_now("in_ready_timeout");
  endtask

  task automatic wait_out_valid(output bit ok);
    int t = 0;
    while (!out_valid && t < 20) begin
      step();
      t++;
    end
    ok = out_valid;
    if (!ok) fail_now("out_valid_timeout");
  endtask

  // Issue one operation; inputs are scrambled right after acceptance.
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic vcin, input logic vsub,
                      input logic [W-1:0] er, input logic ec, input logic ev);
    bit ok;
    wait_in_ready(ok);
    if (!ok) return;
    a = va; b = vb; carry_in = vcin; sub = vsub; in_valid = 1'b1;
    step();
    exp_q.push_back({er, ec, ev});
    lat_q.push_back(cyc);
    in_valid = 1'b0;
    a = ~va; b = ~vb; carry_in = ~vcin; sub = ~vsub;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit ok;
    repeat (3) step();
    rst_n = 1'b1;

    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_carry_out", carry_out, 0);
    check("reset_overflow", overflow, 0);

    // Basic add / subtract vectors
    send(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    send(8'h7F, 8'h01, 1'b0, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1);
    send(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    send(8'h05, 8'h07, 1'b1, 1'b1, 8'hFD, 1'b0, 1'b0);
    send(8'h80, 8'h01, 1'b0, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1);
    send(8'h80, 8'h80, 1'b0, 1'b0, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1);
    send(8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0);
    send(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

    // Backpressure: hold the result in DONE for 10 cycles
    wait_in_ready(ok);
    out_ready = 1'b0;
    send(8'h64, 8'h64, 1'b0, 1'b0, SAT ? 8'h7F : 8'hC8, 1'b0, 1'b1);
    wait_out_valid(ok);
    repeat (10) step();
    out_ready = 1'b1;

    // Reset during RUN at digit 2: the operation is discarded
    wait_in_ready(ok);
    a = 8'h11; b = 8'h22; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrun_reset_in_ready", in_ready, 1);
    check("midrun_reset_out_valid", out_valid, 0);
    check("midrun_reset_result", result, 0);
    send(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

    // Inputs toggled every cycle and in_valid held high through RUN and DONE
    wait_in_ready(ok);
    out_ready = 1'b0;
    a = 8'h12; b = 8'h34; carry_in = 1'b0; sub = 1'b1; in_valid = 1'b1;
    step();
    exp_q.push_back({8'hDE, 1'b0, 1'b0});
    lat_q.push_back(cyc);
    for (int t = 0; t < 20 && !out_valid; t++) begin
      a = ~a; b = ~b; sub = ~sub;
      step();
    end
    if (!out_valid) fail_now("toggle_out_valid_timeout");
    repeat (2) begin
      a = ~a; b = ~b; sub = ~sub;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Drain
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) step();
    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);
    check("latency_queue_drained", lat_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
